// File: rtl/data_mem_pipe_if.sv
// Request/response bundle for the pipelined RV32 data memory.
// The master drives requests and observes responses; the slave is the memory.
interface data_mem_pipe_if #(
  parameter int ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [2:0]        req_func3;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_func3,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_func3,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_pipe.sv
// Pipelined RV32 data memory: sized stores, extending loads, post-reset zero sweep.
// Optional macro DMEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into errors.
module data_mem_pipe #(
  parameter int DEPTH    = 1024,
  parameter int READ_LAT = 1,
  parameter int ADDR_W   = 32
) (
  input  logic           clk,
  input  logic           reset_n,
  data_mem_pipe_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]       state_r;
  logic [IDX_W-1:0] idx_r;
  logic             ready_r;
  logic [31:0]      mem_r [DEPTH];
  logic [READ_LAT-1:0] pv_r;
  logic [READ_LAT-1:0] pe_r;
  logic [31:0]      pd_r [READ_LAT];

  logic              accept_s;
  logic [ADDR_W-1:0] addr_s;
  logic [ADDR_W-3:0] widx_s;
  logic [IDX_W-1:0]  mem_idx_s;
  logic              oor_s;
  logic [1:0]        lane_s;
  logic              f3_bad_s;
  logic              err_s;
  logic [3:0]        wmask_s;
  logic [31:0]       wdata_s;
  logic [31:0]       rword_s;
  logic [7:0]        rbyte_s;
  logic [15:0]       rhalf_s;
  logic [31:0]       ext_s;
  logic [31:0]       ld_s;

  assign accept_s = bus.req_valid & ready_r;

  // Address split, func3 legality and store lane/data steering.
  always_comb begin
    addr_s    = bus.req_addr;
    widx_s    = addr_s[ADDR_W-1:2];
    mem_idx_s = widx_s[IDX_W-1:0];
    oor_s     = (widx_s >> IDX_W) != '0;
    lane_s    = addr_s[1:0];
    f3_bad_s  = 1'b0;
    wmask_s   = 4'b0000;
    wdata_s   = 32'h0000_0000;
    case (bus.req_func3)
      3'b000: begin
        wmask_s = 4'b0001 << lane_s;
        wdata_s = {4{bus.req_wdata[7:0]}};
      end
      3'b001: begin
        wmask_s = addr_s[1] ? 4'b1100 : 4'b0011;
        wdata_s = {2{bus.req_wdata[15:0]}};
      end
      3'b010: begin
        wmask_s = 4'b1111;
        wdata_s = bus.req_wdata;
      end
      3'b100:  f3_bad_s = bus.req_write;
      3'b101:  f3_bad_s = bus.req_write;
      default: f3_bad_s = 1'b1;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic mis_s;

  // Half/word accesses must be naturally aligned in the trapping build.
  always_comb begin
    case (bus.req_func3)
      3'b001:  mis_s = addr_s[0];
      3'b101:  mis_s = addr_s[0];
      3'b010:  mis_s = |addr_s[1:0];
      default: mis_s = 1'b0;
    endcase
  end

  assign err_s = oor_s | f3_bad_s | mis_s;
`else
  assign err_s = oor_s | f3_bad_s;
`endif

  // Load path: pick the lane from the current word, then sign/zero extend.
  always_comb begin
    rword_s = mem_r[mem_idx_s];
    rbyte_s = rword_s[8*lane_s +: 8];
    rhalf_s = addr_s[1] ? rword_s[31:16] : rword_s[15:0];
    case (bus.req_func3)
      3'b000:  ext_s = {{24{rbyte_s[7]}}, rbyte_s};
      3'b001:  ext_s = {{16{rhalf_s[15]}}, rhalf_s};
      3'b010:  ext_s = rword_s;
      3'b100:  ext_s = {24'h00_0000, rbyte_s};
      3'b101:  ext_s = {16'h0000, rhalf_s};
      default: ext_s = 32'h0000_0000;
    endcase
    if (!bus.req_write && !err_s) begin
      ld_s = ext_s;
    end else begin
      ld_s = 32'h0000_0000;
    end
  end

  // Sweep/run controller; the sweep restarts from word 0 on every reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_CLEAR;
      idx_r   <= '0;
      ready_r <= 1'b0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          if (idx_r == IDX_W'(DEPTH - 1)) begin
            state_r <= ST_RUN;
            ready_r <= 1'b1;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        ST_RUN:  ready_r <= 1'b1;
        default: begin
          state_r <= ST_CLEAR;
          idx_r   <= '0;
          ready_r <= 1'b0;
        end
      endcase
    end
  end

  // Storage array: zeroing during the sweep, masked byte writes afterwards.
  always_ff @(posedge clk) begin
    if (state_r == ST_CLEAR) begin
      mem_r[idx_r] <= 32'h0000_0000;
    end else if (accept_s && bus.req_write && !err_s) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask_s[b]) begin
          mem_r[mem_idx_s][8*b +: 8] <= wdata_s[8*b +: 8];
        end
      end
    end
  end

  // Response pipeline; empty slots carry zero data and no error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pv_r <= '0;
      pe_r <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        pd_r[i] <= 32'h0000_0000;
      end
    end else begin
      pv_r[0] <= accept_s;
      pe_r[0] <= accept_s & err_s;
      pd_r[0] <= accept_s ? ld_s : 32'h0000_0000;
      for (int i = 1; i < READ_LAT; i++) begin
        pv_r[i] <= pv_r[i-1];
        pe_r[i] <= pe_r[i-1];
        pd_r[i] <= pd_r[i-1];
      end
    end
  end

  assign bus.req_ready = ready_r;
  assign bus.rsp_valid = pv_r[READ_LAT-1];
  assign bus.rsp_err   = pe_r[READ_LAT-1];
  assign bus.rsp_rdata = pd_r[READ_LAT-1];
endmodule

// File: tb/tb_data_mem_pipe.sv
// Randomised bench for data_mem_pipe against a byte-array reference model.
// Honours DMEM_MISALIGN_TRAP_EN the same way the design does.
module tb_data_mem_pipe;
  localparam int DEPTH    = 64;
  localparam int READ_LAT = 3;
  localparam int ADDR_W   = 32;

  typedef struct {
    int          due;
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic clk;
  logic reset_n;
  data_mem_pipe_if #(.ADDR_W(ADDR_W)) bus ();

  data_mem_pipe #(.DEPTH(DEPTH), .READ_LAT(READ_LAT), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int          checks;
  int          errors;
  int          ncyc;
  bit          mon_en;
  exp_t        q[$];
  logic [7:0]  mm [DEPTH*4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte-addressed little-endian memory following the RV32 load/store rules.
  function automatic void model(input logic w, input logic [31:0] a, input logic [31:0] wd,
                                input logic [2:0] f, output logic [31:0] rd, output logic e);
    int          sz;
    bit          sgn;
    bit          legal;
    logic [31:0] base;
    rd = 32'h0; e = 1'b0; sz = 1; sgn = 1'b0; legal = 1'b1;
    case ({w, f})
      4'b1000: sz = 1;
      4'b1001: sz = 2;
      4'b1010: sz = 4;
      4'b0000: begin sz = 1; sgn = 1'b1; end
      4'b0001: begin sz = 2; sgn = 1'b1; end
      4'b0010: sz = 4;
      4'b0100: sz = 1;
      4'b0101: sz = 2;
      default: legal = 1'b0;
    endcase
    if (!legal || (a >> 2) >= DEPTH) begin
      e = 1'b1;
    end else begin
`ifdef DMEM_MISALIGN_TRAP_EN
      if (a % sz != 0) e = 1'b1;
`endif
      base = a - (a % sz);
      if (!e) begin
        for (int k = 0; k < sz; k++) begin
          if (w) mm[base + k] = wd[8*k +: 8];
          else   rd[8*k +: 8] = mm[base + k];
        end
        if (!w && sgn && sz == 1 && rd[7])  rd[31:8]  = 24'hFF_FFFF;
        if (!w && sgn && sz == 2 && rd[15]) rd[31:16] = 16'hFFFF;
      end
    end
  endfunction

  // Response monitor: checks every cycle against the expected-response queue.
  always @(negedge clk) begin
    ncyc <= ncyc + 1;
    if (mon_en) begin
      chk("req_ready", {31'b0, bus.req_ready}, 32'd1);
      if (q.size() > 0 && q[0].due == ncyc + 1) begin
        chk("rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
        chk("rsp_rdata", bus.rsp_rdata, q[0].d);
        chk("rsp_err", {31'b0, bus.rsp_err}, {31'b0, q[0].e});
        void'(q.pop_front());
      end else begin
        chk("idle_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("idle_rdata", bus.rsp_rdata, 32'd0);
        chk("idle_err", {31'b0, bus.rsp_err}, 32'd0);
      end
    end
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] f, input bit use_c, input logic [31:0] cd, input logic ce);
    exp_t        x;
    logic [31:0] md;
    logic        me;
    @(negedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.req_func3 = f;
    model(w, a, wd, f, md, me);
    x.due = ncyc + READ_LAT;
    x.d   = use_c ? cd : md;
    x.e   = use_c ? ce : me;
    q.push_back(x);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic chk_zero_out(input string tag);
    chk({tag, "_ready"}, {31'b0, bus.req_ready}, 32'd0);
    chk({tag, "_valid"}, {31'b0, bus.rsp_valid}, 32'd0);
    chk({tag, "_rdata"}, bus.rsp_rdata, 32'd0);
    chk({tag, "_err"}, {31'b0, bus.rsp_err}, 32'd0);
  endtask

  // Reset for 10 cycles, then time the zero sweep while offering a store that must be ignored.
  task automatic reset_and_sweep();
    int n;
    @(negedge clk); #1;
    reset_n = 1'b0;
    mon_en = 1'b0;
    bus.req_valid = 1'b0;
    q.delete();
    repeat (10) @(posedge clk);
    #1 chk_zero_out("in_reset");
    @(negedge clk); #1;
    reset_n = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h40;
    bus.req_wdata = 32'hDEAD_BEEF;
    bus.req_func3 = 3'b010;
    n = 0;
    while (n < 4 * DEPTH) begin
      @(posedge clk); n++;
      #1;
      if (bus.req_ready) break;
    end
    bus.req_valid = 1'b0;
    chk("sweep_len", n, DEPTH);
    for (int i = 0; i < DEPTH * 4; i++) mm[i] = 8'h00;
    mon_en = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < READ_LAT + 10) begin
      @(negedge clk); n++;
    end
    #2 chk("drain", q.size(), 0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] exp_lw6;
    logic        exp_lw6_e;
    checks = 0; errors = 0; ncyc = 0; mon_en = 1'b0;
    reset_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
    bus.req_wdata = 32'h0; bus.req_func3 = 3'b000;

    reset_and_sweep();
    issue(1'b0, 32'h40, 32'h0, 3'b010, 1'b1, 32'h0000_0000, 1'b0);

    issue(1'b1, 32'h04, 32'hFF00_FF00, 3'b010, 1'b1, 32'h0, 1'b0);
    issue(1'b0, 32'h04, 32'h0, 3'b010, 1'b1, 32'hFF00_FF00, 1'b0);

    issue(1'b1, 32'h14, 32'hAAAA_AAAA, 3'b010, 1'b1, 32'h0, 1'b0);
    issue(1'b1, 32'h15, 32'hABCD_EDEF, 3'b000, 1'b1, 32'h0, 1'b0);
    issue(1'b0, 32'h15, 32'h0, 3'b000, 1'b1, 32'hFFFF_FFEF, 1'b0);
    issue(1'b0, 32'h15, 32'h0, 3'b100, 1'b1, 32'h0000_00EF, 1'b0);
    issue(1'b0, 32'h14, 32'h0, 3'b010, 1'b1, 32'hAAAA_EFAA, 1'b0);

    issue(1'b1, 32'h1A, 32'hABCD_EDEF, 3'b001, 1'b1, 32'h0, 1'b0);
    issue(1'b0, 32'h1A, 32'h0, 3'b001, 1'b1, 32'hFFFF_EDEF, 1'b0);
    issue(1'b0, 32'h1A, 32'h0, 3'b101, 1'b1, 32'h0000_EDEF, 1'b0);
    issue(1'b0, 32'h18, 32'h0, 3'b010, 1'b1, 32'hEDEF_0000, 1'b0);

`ifdef DMEM_MISALIGN_TRAP_EN
    exp_lw6 = 32'h0000_0000; exp_lw6_e = 1'b1;
`else
    exp_lw6 = 32'hFF00_FF00; exp_lw6_e = 1'b0;
`endif
    issue(1'b0, 32'h06, 32'h0, 3'b010, 1'b1, exp_lw6, exp_lw6_e);
    issue(1'b0, 32'h04, 32'h0, 3'b011, 1'b1, 32'h0, 1'b1);
    issue(1'b0, DEPTH * 4, 32'h0, 3'b010, 1'b1, 32'h0, 1'b1);
    issue(1'b1, DEPTH * 4 + 4, 32'h1234_5678, 3'b010, 1'b1, 32'h0, 1'b1);
    issue(1'b1, 32'h04, 32'h1234_5678, 3'b100, 1'b1, 32'h0, 1'b1);
    issue(1'b0, 32'h04, 32'h0, 3'b010, 1'b1, 32'hFF00_FF00, 1'b0);
    idle(READ_LAT + 2);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        case ($urandom_range(0, 9))
          0:       a = $urandom;
          1:       a = DEPTH * 4 + $urandom_range(0, 15);
          default: a = $urandom_range(0, 63);
        endcase
        issue($urandom_range(0, 1) == 1, a, $urandom, 3'($urandom_range(0, 7)), 1'b0, 32'h0, 1'b0);
      end
    end
    idle(1);
    drain();

    // Reset in the middle of the sweep, then a full sweep.
    @(negedge clk); #1;
    reset_n = 1'b0; mon_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1 reset_n = 1'b1;
    repeat (7) @(posedge clk);
    reset_and_sweep();

    // Back-to-back burst interrupted by an asynchronous reset.
    for (int i = 0; i < 5; i++) begin
      issue(i[0], 32'h20 + 32'(4 * i), $urandom, 3'b010, 1'b0, 32'h0, 1'b0);
    end
    @(negedge clk); #2;
    reset_n = 1'b0;
    mon_en = 1'b0;
    #1 chk_zero_out("async_rst");
    q.delete();
    reset_and_sweep();
    issue(1'b0, 32'h24, 32'h0, 3'b010, 1'b1, 32'h0, 1'b0);
    issue(1'b0, 32'h04, 32'h0, 3'b010, 1'b1, 32'h0, 1'b0);
    idle(1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
